// File: rtl/regfile_mp_if.sv
// Register file bus: decode-side read/reserve/flush and writeback-side write.
// Ports:
//   slave  - register file side (receives write/read/reserve, drives data/busy)
//   master - pipeline side (drives write/read/reserve, receives data/busy)
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              Reserve;
    logic [ADDR_W-1:0] ReserveReg;
    logic              Flush;
    logic              Busy1;
    logic              Busy2;

    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        input  Reserve, ReserveReg, Flush,
        output ReadData1, ReadData2, Busy1, Busy2
    );

    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        output Reserve, ReserveReg, Flush,
        input  ReadData1, ReadData2, Busy1, Busy2
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard.
// One write port (writeback), two read ports (decode), one reserve port and
// a flush that clears every busy bit. Optional hardwired zero register,
// write-to-read bypass and registered (1-cycle) read outputs.
// Ports:
//   Clk    - clock, all state updates on rising edge
//   Rst_n  - asynchronous active-low clear of registers, busy bits, outputs
//   bus    - regfile_mp_if.slave carrying write/read/reserve/flush signals
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int SYNC_READ = 0
) (
    input  logic         Clk,
    input  logic         Rst_n,
    regfile_mp_if.slave  bus
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic              wr_ok_s;
    logic              rsv_ok_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic              bz1_s;
    logic              bz2_s;

    // Address is usable when inside DEPTH and not the hardwired zero register.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        logic ok;
        ok = (int'(a) < DEPTH);
        if ((ZERO_REG != 0) && (a == '0)) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

    // Read value for one port: zero for invalid, bypass, else stored word.
    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (!addr_valid(a)) begin
            v = '0;
        end else if ((BYPASS != 0) && bus.RegWrite && (bus.WriteReg == a)) begin
            v = bus.WriteData;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                v = (int'(a) == i) ? regs_q[i] : v;
            end
        end
        return v;
    endfunction

    // Busy for one port: a bypassed write hides the stale busy bit unless the
    // same register is being re-reserved on this edge.
    function automatic logic bz_val(input logic [ADDR_W-1:0] a);
        logic b;
        b = 1'b0;
        if (!addr_valid(a)) begin
            b = 1'b0;
        end else if ((BYPASS != 0) && bus.RegWrite && (bus.WriteReg == a) &&
                     !(rsv_ok_s && (bus.ReserveReg == a))) begin
            b = 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                b = (int'(a) == i) ? busy_q[i] : b;
            end
        end
        return b;
    endfunction

    // Qualified write/reserve strobes; flush drops any reserve in its cycle.
    always_comb begin
        wr_ok_s  = bus.RegWrite && addr_valid(bus.WriteReg);
        rsv_ok_s = bus.Reserve && !bus.Flush && addr_valid(bus.ReserveReg);
    end

    // Busy next state: reserve beats write-release beats flush/hold.
    always_comb begin
        busy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_d[i] = (rsv_ok_s && (int'(bus.ReserveReg) == i)) ? 1'b1 :
                        (wr_ok_s && (int'(bus.WriteReg) == i))    ? 1'b0 :
                        bus.Flush                                  ? 1'b0 :
                                                                     busy_q[i];
        end
    end

    // Register array and busy scoreboard storage.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok_s && (int'(bus.WriteReg) == i)) begin
                    regs_q[i] <= bus.WriteData;
                end else begin
                    regs_q[i] <= regs_q[i];
                end
            end
            busy_q <= busy_d;
        end
    end

    // Per-port read data and busy status before optional output register.
    always_comb begin
        rd1_s = rd_val(bus.ReadReg1);
        rd2_s = rd_val(bus.ReadReg2);
        bz1_s = bz_val(bus.ReadReg1);
        bz2_s = bz_val(bus.ReadReg2);
    end

    generate
        if (SYNC_READ != 0) begin : g_sync_read
            logic [DATA_W-1:0] rd1_q;
            logic [DATA_W-1:0] rd2_q;
            logic              bz1_q;
            logic              bz2_q;

            // Registered read outputs, one cycle after the address.
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    rd1_q <= '0;
                    rd2_q <= '0;
                    bz1_q <= 1'b0;
                    bz2_q <= 1'b0;
                end else begin
                    rd1_q <= rd1_s;
                    rd2_q <= rd2_s;
                    bz1_q <= bz1_s;
                    bz2_q <= bz2_s;
                end
            end

            assign bus.ReadData1 = rd1_q;
            assign bus.ReadData2 = rd2_q;
            assign bus.Busy1     = bz1_q;
            assign bus.Busy2     = bz2_q;
        end else begin : g_comb_read
            assign bus.ReadData1 = rd1_s;
            assign bus.ReadData2 = rd2_s;
            assign bus.Busy1     = bz1_s;
            assign bus.Busy2     = bz2_s;
        end
    endgenerate

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, dual-read register memory used by the CPU datapath.
- Adds:
  - asynchronous clear of all registers
  - optional hardwired zero register
  - write-to-read bypass
  - selectable combinational or registered read
  - per-register busy scoreboard (reserve on issue, release on writeback) for multicycle/pipelined hazard detection
- Sits between decode (read/reserve) and writeback (write).

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 5, register address width
DEPTH, 32, number of registers; must be <= 2**ADDR_W
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes/reserves
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports
SYNC_READ, 0, 0 = combinational read; 1 = read data/busy registered, 1-cycle latency

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst_n  input  1  asynchronous active-low reset
RegWrite  input  1  write enable
WriteReg  input  ADDR_W  write address
WriteData  input  DATA_W  write data
ReadReg1  input  ADDR_W  read port 1 address
ReadReg2  input  ADDR_W  read port 2 address
ReadData1  output  DATA_W  read port 1 data
ReadData2  output  DATA_W  read port 2 data
Reserve  input  1  mark ReserveReg busy (pending writeback)
ReserveReg  input  ADDR_W  register to reserve
Flush  input  1  synchronous clear of all busy bits
Busy1  output  1  busy status of ReadReg1
Busy2  output  1  busy status of ReadReg2

Behaviour:
Reset:
- Rst_n low clears all DEPTH registers and all busy bits immediately, independent of Clk.
- With SYNC_READ=1, ReadData1/2 and Busy1/2 also go to 0.
- Reset asserted mid-operation discards any write/reserve in that cycle.
- First write is accepted on the first rising edge after Rst_n deasserts.

Valid address:
- An address is valid if it is < DEPTH and not (ZERO_REG=1 and address==0).

Write:
- On a rising edge with RegWrite=1 and WriteReg valid: reg[WriteReg] <= WriteData, and busy[WriteReg] <= 0.
- Invalid WriteReg: no state change.

Reserve:
- On a rising edge with Reserve=1 and ReserveReg valid: busy[ReserveReg] <= 1.

Simultaneous events, priority highest first:
1. Flush: all busy bits <= 0; any reserve in that cycle is dropped. Data writes still occur.
2. Reserve to the same register as a write: busy ends 1, data is still written.
3. Write, reserve and flush to different registers are applied independently.

Read value for port N, rd(N):
- If ReadRegN >= DEPTH, or ZERO_REG=1 and ReadRegN==0: 0.
- Else if BYPASS=1, RegWrite=1 and WriteReg==ReadRegN: WriteData.
- Else: reg[ReadRegN].
- Both ports are independent; the same address on both ports is legal.

Busy for port N, bz(N):
- If ReadRegN is invalid: 0.
- Else if BYPASS=1, RegWrite=1, WriteReg==ReadRegN and no same-cycle reserve to that register: 0.
- Else: busy[ReadRegN].

Output timing:
- SYNC_READ=0: ReadDataN = rd(N) and BusyN = bz(N), combinationally, in the same cycle.
- SYNC_READ=1: ReadDataN and BusyN are registered from rd(N)/bz(N) at the rising edge; valid the cycle after the address is presented.
- SYNC_READ=1, BYPASS=0: a read of the address written on the same edge returns the old value.

Width rules:
- No truncation or extension; all data paths are DATA_W.

Test Plan:
- Reset then read: Rst_n pulse low for 3 ns mid-cycle after writing reg5=0xDEADBEEF -> ReadData1 with ReadReg1=5 reads 0x00000000 immediately, Busy1=0.
- Write/read with bypass (defaults): RegWrite=1, WriteReg=7, WriteData=0x12345678, ReadReg1=7 in the same cycle -> ReadData1=0x12345678 before the edge; after the edge, with RegWrite=0, it still reads 0x12345678.
- Zero register: write 0xFFFFFFFF to reg0, then reserve reg0 -> ReadData1=0, Busy1=0.
- Scoreboard:
  - Reserve reg3 at cycle 1 -> Busy2=1 (ReadReg2=3) from cycle 2.
  - Write reg3=0xA5 at cycle 4 -> Busy2=0 and ReadData2=0xA5 from cycle 5.
  - Reserve and write reg3 on the same edge -> Busy stays 1, data=new value.
- Flush priority: busy on reg2 and reg9, then Flush=1 together with Reserve reg4 -> next cycle all busy bits 0, including reg4.
- SYNC_READ=1, BYPASS=0, DEPTH=16: write reg4=0x55 while ReadReg1=4 -> the next cycle shows the old value 0; the following cycle shows 0x55; ReadReg1=20 -> 0.
